// File: rtl/imem_responder.sv
// imem_responder: fixed-latency, fully pipelined instruction fetch responder with preload port.
// Optional IMEM_BOUNDS_CHECK_EN adds illegal-fetch detection (err, err_addr).
module imem_responder #(
  parameter int          DEPTH    = 1024,
  parameter int          LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          exIns_ren,
  input  logic [31:0]   exIns_addr,
  output logic          exIns_valid,
  output logic [31:0]   exIns_in,
  input  logic          ld_wen,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic [31:0]   req_cnt,
  output logic          err,
  output logic [31:0]   err_addr
);
  logic [31:0]        mem [DEPTH];
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [31:0]        dat_q [LATENCY];
  logic [31:0]        dat_d [LATENCY];
  logic [31:0]        cnt_q, cnt_d;
  logic [LATENCY:0]   v_in;
  logic [31:0]        d_in [LATENCY+1];
`ifdef IMEM_BOUNDS_CHECK_EN
  logic               illegal;
  logic [LATENCY-1:0] ill_q, ill_d;
  logic [LATENCY:0]   i_in;
  logic [31:0]        a_q [LATENCY];
  logic [31:0]        a_d [LATENCY];
  logic [31:0]        a_in [LATENCY+1];
  logic               err_q, err_d;
  logic [31:0]        ea_q, ea_d;
`endif

  // Index v_in/d_in[k] is what enters stage k at the next edge; data only moves with a valid.
  always_comb begin
    v_in = {vld_q, exIns_ren};
`ifdef IMEM_BOUNDS_CHECK_EN
    illegal = (|exIns_addr[1:0]) || (|exIns_addr[31:AW+2]);
    d_in[0] = illegal ? NOP_WORD : mem[exIns_addr[AW+1:2]];
    i_in = {ill_q, illegal};
    a_in[0] = exIns_addr;
`else
    d_in[0] = mem[exIns_addr[AW+1:2]];
`endif
    for (int k = 0; k < LATENCY; k++) begin
      d_in[k+1] = dat_q[k];
      vld_d[k] = v_in[k];
      dat_d[k] = v_in[k] ? d_in[k] : dat_q[k];
`ifdef IMEM_BOUNDS_CHECK_EN
      a_in[k+1] = a_q[k];
      ill_d[k] = i_in[k];
      a_d[k] = v_in[k] ? a_in[k] : a_q[k];
`endif
    end
    cnt_d = cnt_q + 32'(exIns_ren);
`ifdef IMEM_BOUNDS_CHECK_EN
    err_d = err_q | (v_in[LATENCY-1] & i_in[LATENCY-1]);
    ea_d = (!err_q && v_in[LATENCY-1] && i_in[LATENCY-1]) ? a_in[LATENCY-1] : ea_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      vld_q <= '0;
      dat_q <= '{default: NOP_WORD};
      cnt_q <= '0;
`ifdef IMEM_BOUNDS_CHECK_EN
      ill_q <= '0;
      a_q   <= '{default: '0};
      err_q <= 1'b0;
      ea_q  <= '0;
`endif
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
`ifdef IMEM_BOUNDS_CHECK_EN
      ill_q <= ill_d;
      a_q   <= a_d;
      err_q <= err_d;
      ea_q  <= ea_d;
`endif
    end
  end

  // Non-blocking write gives read-before-write on a same-edge fetch.
  always_ff @(posedge clk) begin
    if (nrst && ld_wen) mem[ld_addr] <= ld_data;
  end

  assign exIns_valid = vld_q[LATENCY-1];
  assign exIns_in    = dat_q[LATENCY-1];
  assign req_cnt     = cnt_q;
`ifdef IMEM_BOUNDS_CHECK_EN
  assign err      = err_q;
  assign err_addr = ea_q;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{exIns_addr[31:AW+2], exIns_addr[1:0]};
  assign err      = 1'b0;
  assign err_addr = '0;
`endif
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: table-driven check of imem_responder at LATENCY 1/2 plus LATENCY 3 reset-drop sequences.
module tb_imem_responder;
  localparam logic [31:0] N  = 32'h0000_0013;
  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h0010_8113;
  localparam logic [31:0] W2 = 32'h0020_81B3;
  localparam logic [31:0] W3 = 32'h0000_006F;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] X1 = 32'h1111_1111;
  localparam logic [31:0] X2 = 32'h2222_2222;
`ifdef IMEM_BOUNDS_CHECK_EN
  localparam logic        BC = 1'b1;
  localparam logic [31:0] B  = N;
  localparam logic [31:0] E  = 32'h0000_0002;
`else
  localparam logic        BC = 1'b0;
  localparam logic [31:0] B  = W0;
  localparam logic [31:0] E  = 32'h0000_0000;
`endif

  typedef struct {
    logic        n, r;
    logic [31:0] a;
    logic        w;
    logic [9:0]  la;
    logic [31:0] ld;
    logic        v1;
    logic [31:0] d1;
    logic        v2;
    logic [31:0] d2;
    logic [31:0] c;
    logic        er;
    logic [31:0] ea;
  } vec_t;

  logic        clk = 1'b0, nrst = 1'b0, ren = 1'b0, wen = 1'b0;
  logic [31:0] addr = '0, ld_data = '0;
  logic [9:0]  ld_addr = '0;
  logic        v1, v2, v3, e1, e2, e3;
  logic [31:0] d1, d2, d3, c1, c2, c3, ea1, ea2, ea3;
  int          n_cmp = 0, n_bad = 0;
  vec_t        tbl [29];

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(1)) u1 (.clk(clk), .nrst(nrst), .exIns_ren(ren), .exIns_addr(addr),
    .exIns_valid(v1), .exIns_in(d1), .ld_wen(wen), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_cnt(c1), .err(e1), .err_addr(ea1));
  imem_responder #(.LATENCY(2)) u2 (.clk(clk), .nrst(nrst), .exIns_ren(ren), .exIns_addr(addr),
    .exIns_valid(v2), .exIns_in(d2), .ld_wen(wen), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_cnt(c2), .err(e2), .err_addr(ea2));
  imem_responder #(.LATENCY(3)) u3 (.clk(clk), .nrst(nrst), .exIns_ren(ren), .exIns_addr(addr),
    .exIns_valid(v3), .exIns_in(d3), .ld_wen(wen), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_cnt(c3), .err(e3), .err_addr(ea3));

  function automatic vec_t mk(logic n, logic r, logic [31:0] a, logic w, logic [9:0] la,
      logic [31:0] ld, logic xv1, logic [31:0] xd1, logic xv2, logic [31:0] xd2,
      logic [31:0] c, logic er, logic [31:0] ea);
    mk = '{n, r, a, w, la, ld, xv1, xd1, xv2, xd2, c, er, ea};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic n, logic r, logic [31:0] a);
    nrst = n; ren = r; addr = a; wen = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1'b0, 1'b0, 32'h0,    1'b0, 10'd0, 32'h0, 1'b0, N,  1'b0, N,  32'd0,  1'b0, 32'h0);
    tbl[1]  = mk(1'b0, 1'b1, 32'h0,    1'b0, 10'd0, 32'h0, 1'b0, N,  1'b0, N,  32'd0,  1'b0, 32'h0);
    tbl[2]  = mk(1'b1, 1'b0, 32'h0,    1'b1, 10'd0, W0,    1'b0, N,  1'b0, N,  32'd0,  1'b0, 32'h0);
    tbl[3]  = mk(1'b1, 1'b0, 32'h0,    1'b1, 10'd1, W1,    1'b0, N,  1'b0, N,  32'd0,  1'b0, 32'h0);
    tbl[4]  = mk(1'b1, 1'b0, 32'h0,    1'b1, 10'd2, W2,    1'b0, N,  1'b0, N,  32'd0,  1'b0, 32'h0);
    tbl[5]  = mk(1'b1, 1'b0, 32'h0,    1'b1, 10'd3, W3,    1'b0, N,  1'b0, N,  32'd0,  1'b0, 32'h0);
    tbl[6]  = mk(1'b1, 1'b0, 32'h0,    1'b1, 10'd5, N,     1'b0, N,  1'b0, N,  32'd0,  1'b0, 32'h0);
    tbl[7]  = mk(1'b1, 1'b0, 32'h0,    1'b1, 10'd6, X1,    1'b0, N,  1'b0, N,  32'd0,  1'b0, 32'h0);
    tbl[8]  = mk(1'b1, 1'b1, 32'h0,    1'b0, 10'd0, 32'h0, 1'b1, W0, 1'b0, N,  32'd1,  1'b0, 32'h0);
    tbl[9]  = mk(1'b1, 1'b1, 32'h4,    1'b0, 10'd0, 32'h0, 1'b1, W1, 1'b1, W0, 32'd2,  1'b0, 32'h0);
    tbl[10] = mk(1'b1, 1'b1, 32'h8,    1'b0, 10'd0, 32'h0, 1'b1, W2, 1'b1, W1, 32'd3,  1'b0, 32'h0);
    tbl[11] = mk(1'b1, 1'b1, 32'hC,    1'b0, 10'd0, 32'h0, 1'b1, W3, 1'b1, W2, 32'd4,  1'b0, 32'h0);
    tbl[12] = mk(1'b1, 1'b0, 32'h0,    1'b0, 10'd0, 32'h0, 1'b0, W3, 1'b1, W3, 32'd4,  1'b0, 32'h0);
    tbl[13] = mk(1'b1, 1'b0, 32'h0,    1'b0, 10'd0, 32'h0, 1'b0, W3, 1'b0, W3, 32'd4,  1'b0, 32'h0);
    tbl[14] = mk(1'b1, 1'b1, 32'h14,   1'b1, 10'd5, DB,    1'b1, N,  1'b0, W3, 32'd5,  1'b0, 32'h0);
    tbl[15] = mk(1'b1, 1'b1, 32'h14,   1'b0, 10'd0, 32'h0, 1'b1, DB, 1'b1, N,  32'd6,  1'b0, 32'h0);
    tbl[16] = mk(1'b1, 1'b0, 32'h0,    1'b0, 10'd0, 32'h0, 1'b0, DB, 1'b1, DB, 32'd6,  1'b0, 32'h0);
    tbl[17] = mk(1'b1, 1'b1, 32'h0,    1'b0, 10'd0, 32'h0, 1'b1, W0, 1'b0, DB, 32'd7,  1'b0, 32'h0);
    tbl[18] = mk(1'b1, 1'b0, 32'h0,    1'b0, 10'd0, 32'h0, 1'b0, W0, 1'b1, W0, 32'd7,  1'b0, 32'h0);
    tbl[19] = mk(1'b1, 1'b1, 32'h4,    1'b0, 10'd0, 32'h0, 1'b1, W1, 1'b0, W0, 32'd8,  1'b0, 32'h0);
    tbl[20] = mk(1'b1, 1'b1, 32'h8,    1'b0, 10'd0, 32'h0, 1'b1, W2, 1'b1, W1, 32'd9,  1'b0, 32'h0);
    tbl[21] = mk(1'b1, 1'b0, 32'h0,    1'b0, 10'd0, 32'h0, 1'b0, W2, 1'b1, W2, 32'd9,  1'b0, 32'h0);
    tbl[22] = mk(1'b1, 1'b1, 32'h2,    1'b0, 10'd0, 32'h0, 1'b1, B,  1'b0, W2, 32'd10, BC,   E);
    tbl[23] = mk(1'b1, 1'b1, 32'h1000, 1'b0, 10'd0, 32'h0, 1'b1, B,  1'b1, B,  32'd11, BC,   E);
    tbl[24] = mk(1'b1, 1'b0, 32'h0,    1'b0, 10'd0, 32'h0, 1'b0, B,  1'b1, B,  32'd11, BC,   E);
    tbl[25] = mk(1'b1, 1'b0, 32'h0,    1'b0, 10'd0, 32'h0, 1'b0, B,  1'b0, B,  32'd11, BC,   E);
    tbl[26] = mk(1'b0, 1'b1, 32'h0,    1'b1, 10'd6, X2,    1'b0, N,  1'b0, N,  32'd0,  1'b0, 32'h0);
    tbl[27] = mk(1'b1, 1'b1, 32'h18,   1'b0, 10'd0, 32'h0, 1'b1, X1, 1'b0, N,  32'd1,  1'b0, 32'h0);
    tbl[28] = mk(1'b1, 1'b0, 32'h0,    1'b0, 10'd0, 32'h0, 1'b0, X1, 1'b1, X1, 32'd1,  1'b0, 32'h0);

    for (int i = 0; i < 29; i++) begin
      nrst = tbl[i].n; ren = tbl[i].r; addr = tbl[i].a;
      wen = tbl[i].w; ld_addr = tbl[i].la; ld_data = tbl[i].ld;
      tick();
      chk($sformatf("row%0d L1 valid", i), {31'b0, v1}, {31'b0, tbl[i].v1});
      chk($sformatf("row%0d L1 data", i), d1, tbl[i].d1);
      chk($sformatf("row%0d L2 valid", i), {31'b0, v2}, {31'b0, tbl[i].v2});
      chk($sformatf("row%0d L2 data", i), d2, tbl[i].d2);
      chk($sformatf("row%0d req_cnt", i), c1, tbl[i].c);
      chk($sformatf("row%0d err", i), {31'b0, e1}, {31'b0, tbl[i].er});
      chk($sformatf("row%0d err_addr", i), ea1, tbl[i].ea);
    end

    drive(1'b1, 1'b0, 32'h0);
    repeat (4) tick();
    chk("L3 cnt before", c3, 32'd1);
    drive(1'b1, 1'b1, 32'h4);
    tick();
    chk("L3 resp t+0", {31'b0, v3}, 32'd0);
    drive(1'b1, 1'b0, 32'h0);
    tick();
    chk("L3 resp t+1", {31'b0, v3}, 32'd0);
    tick();
    chk("L3 resp t+2 valid", {31'b0, v3}, 32'd1);
    chk("L3 resp t+2 data", d3, W1);
    tick();
    chk("L3 resp t+3", {31'b0, v3}, 32'd0);
    chk("L3 cnt", c3, 32'd2);

    drive(1'b1, 1'b1, 32'h8);
    tick();
    chk("drop L1 valid", {31'b0, v1}, 32'd1);
    chk("drop L1 data", d1, W2);
    chk("drop L3 cnt pre", c3, 32'd3);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk("drop L3 valid at reset", {31'b0, v3}, 32'd0);
    chk("drop L3 data at reset", d3, N);
    chk("drop L3 cnt", c3, 32'd0);
    chk("drop L2 valid at reset", {31'b0, v2}, 32'd0);
    drive(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("drop L3 quiet %0d", i), {31'b0, v3}, 32'd0);
      chk($sformatf("drop L2 quiet %0d", i), {31'b0, v2}, 32'd0);
    end
    chk("drop L3 cnt post", c3, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the core's external fetch interface. It samples fetch requests (`exIns_ren` and `exIns_addr`) and returns the addressed word on `exIns_valid` and `exIns_in` after a fixed, parameterised latency. Back-to-back requests are fully pipelined. A load port preloads program images. The block sits outside the core, between the core's fetch port and the testbench or SoC program store.

## Interface
- `DEPTH`, default 1024: number of 32-bit words; power of two, 16..65536.
- `LATENCY`, default 1: edges from request sample to response; legal range 1..4.
- `NOP_WORD`, default 32'h0000_0013: word returned in place of illegal fetches and driven at reset.
- Clock and reset: one clock; reset is synchronous and active-low. Ports `clk` and `nrst`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `nrst`  in  1  synchronous active-low reset.
- `exIns_ren`  in  1  fetch request, sampled every edge.
- `exIns_addr`  in  32  byte address of the fetch.
- `exIns_valid`  out  1  response valid, exactly one cycle per accepted request.
- `exIns_in`  out  32  fetched instruction word.
- `ld_wen`  in  1  preload write enable.
- `ld_addr`  in  log2(DEPTH)  word index for preload.
- `ld_data`  in  32  preload data.
- `req_cnt`  out  32  count of accepted requests; wraps at 2^32.
- `err`  out  1  sticky illegal-fetch flag; present only under the macro, otherwise tied 0.
- `err_addr`  out  32  address of the first illegal fetch; tied 0 without the macro.

## Operation
- No ready/backpressure: every edge with `exIns_ren`=1 accepts a request.
- Word index is `exIns_addr[log2(DEPTH)+1:2]`.
- Stage 0 reads the array at the accepting edge. Request metadata (valid, data, illegal bit) then shifts through `LATENCY`-1 further register stages. The last stage drives the outputs.
- Responses are always in request order. With no request in the final stage, `exIns_valid`=0 and `exIns_in` holds its last value.
- Preload write: when `ld_wen`=1, `mem[ld_addr]` is written at the edge.
- Fetch and preload to the same word at the same edge: the fetch returns the OLD word (read-before-write). The new word is visible from the next edge.
- `req_cnt` increments by 1 per accepted request.
- Reset (`nrst`=0 at an edge):
  - Clears every pipeline valid bit, so in-flight requests are dropped with no response.
  - `exIns_valid`=0, `exIns_in`=NOP_WORD, `req_cnt`=0, `err`=0, `err_addr`=0.
  - Memory contents are preserved.
  - Requests and preloads presented during reset are ignored.

## Timing
- A request sampled at edge t produces `exIns_valid`=1 during the cycle after edge t+LATENCY-1.
  - LATENCY=1: response in the cycle immediately following the request cycle.
- Throughput is one response per cycle. N consecutive request cycles yield N consecutive valid cycles, shifted by LATENCY.
- Reset asserted at edge t: no response appears after edge t, even for requests sampled before t.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `IMEM_BOUNDS_CHECK_EN`.
- Defined:
  - A fetch is illegal if `exIns_addr[1:0]`≠0 or `exIns_addr` ≥ 4·DEPTH.
  - An illegal fetch still responds, with normal latency and `exIns_in`=NOP_WORD.
  - `err` goes to 1 at the response edge and stays 1 until reset.
  - `err_addr` captures the address of the first illegal fetch only.
- Undefined:
  - Low 2 bits and upper address bits are ignored; the address wraps modulo DEPTH.
  - `err`, `err_addr` are tied 0 and the check logic is absent.

## Test plan
- Reset then idle: `nrst`=0 for 2 edges → `exIns_valid`=0, `exIns_in`=32'h0000_0013, `req_cnt`=0.
- Preload `mem[0..3]`={32'h00500093, 32'h00108113, 32'h002081B3, 32'h0000006F}, then `ren`=1 for 4 cycles at addrs 0,4,8,C with LATENCY=2 → 4 consecutive valid cycles carrying those words in order, starting 2 cycles after the first request; `req_cnt`=4.
- Same-edge preload `mem[5]`=32'hDEADBEEF and fetch addr 0x14 (old value 32'h00000013) → response 32'h00000013; a repeat fetch returns 32'hDEADBEEF.
- LATENCY=3, request at edge t, `nrst`=0 at t+1 → no `exIns_valid` pulse; `req_cnt`=0 after reset.
- With `IMEM_BOUNDS_CHECK_EN`, DEPTH=1024:
  - Fetch 0x0000_0002 then 0x0000_1000 → both respond with NOP_WORD; `err`=1 and `err_addr`=32'h0000_0002.
  - Without the macro, 0x0000_1000 returns `mem[0]` and `err`=0.
- Gapped traffic: `ren` pattern 1,0,1,1,0 with LATENCY=1 → valid pattern 0,1,0,1,1 (one cycle later), with matching data.
